// File: rtl/trap_pkg.sv
// Shared constants for the CP0-lite trap controller: ExcCodes, CP0 register
// addresses, Status bit positions, supported opcodes, FSM states and ERET.
package trap_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_TCNT   = 5'd22;

  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 10;
  localparam int unsigned ST_IM_HI = 15;

  localparam logic [31:0] ERET_INSTR    = 32'h4200_0018;
  localparam logic [5:0]  FUNCT_SYSCALL = 6'd12;
  localparam logic [5:0]  FUNCT_BREAK   = 6'd13;

  // Opcodes the core implements; anything else raises RI.
  localparam int unsigned N_SUP_OP = 21;
  localparam logic [5:0] SUP_OPS [N_SUP_OP] = '{
    6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
    6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h20, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
    6'h2B
  };

  typedef enum logic {
    S_NORMAL  = 1'b0,
    S_HANDLER = 1'b1
  } state_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < N_SUP_OP; k++)
      if (SUP_OPS[k] == op) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/trap_decode.sv
// Combinational trap classification and priority selection for trap_ctrl.
// Priority: Int > AdEL > RI > Sys > Bp > Ov > AdES; ERET returns only from HANDLER.
module trap_decode
  import trap_pkg::*;
(
  input  logic        i_squash,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  input  logic        i_ov_err,
  input  logic        i_adel_err,
  input  logic        i_ades_err,
  input  logic [5:0]  i_irq_pend,
  input  logic [5:0]  i_im,
  input  logic        i_ie,
  input  logic        i_exl,
  output logic        o_trap,
  output logic        o_eret,
  output logic        o_is_sys,
  output logic        o_is_bp,
  output logic [4:0]  o_code
);

  logic       w_live;
  logic       w_int;
  logic       w_sys;
  logic       w_bp;
  logic       w_eret_enc;
  logic       w_ri;
  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op       = i_instr[31:26];
  assign w_funct    = i_instr[5:0];
  assign w_live     = i_instr_valid & ~i_squash;
  assign w_int      = ~i_squash & i_ie & ~i_exl & (|(i_irq_pend & i_im));
  assign w_sys      = (w_op == 6'd0) && (w_funct == FUNCT_SYSCALL);
  assign w_bp       = (w_op == 6'd0) && (w_funct == FUNCT_BREAK);
  assign w_eret_enc = (i_instr == ERET_INSTR);
  // ERET outside the handler is treated as a reserved instruction.
  assign w_ri       = ~op_supported(w_op) | (w_eret_enc & ~i_exl);

  // Pick the highest-priority pending cause; ERET only if nothing traps.
  always_comb begin
    o_trap   = 1'b0;
    o_is_sys = 1'b0;
    o_is_bp  = 1'b0;
    o_code   = EXC_INT;
    if (w_int) begin
      o_trap = 1'b1;
      o_code = EXC_INT;
    end else if (w_live && i_adel_err) begin
      o_trap = 1'b1;
      o_code = EXC_ADEL;
    end else if (w_live && w_ri) begin
      o_trap = 1'b1;
      o_code = EXC_RI;
    end else if (w_live && w_sys) begin
      o_trap   = 1'b1;
      o_is_sys = 1'b1;
      o_code   = EXC_SYS;
    end else if (w_live && w_bp) begin
      o_trap  = 1'b1;
      o_is_bp = 1'b1;
      o_code  = EXC_BP;
    end else if (w_live && i_ov_err) begin
      o_trap = 1'b1;
      o_code = EXC_OV;
    end else if (w_live && i_ades_err) begin
      o_trap = 1'b1;
      o_code = EXC_ADES;
    end
    o_eret = w_live & w_eret_enc & i_exl & ~o_trap;
  end

endmodule

// File: rtl/trap_ctrl.sv
// CP0-lite trap controller beside the commit stage: prioritises traps,
// latches EPC/Cause/Status and issues a registered one-cycle redirect.
// Optional TRAP_CNT_EN adds a saturating trap counter at CP0 address 22.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned       PC_W        = 32,
  parameter int unsigned       N_IRQ       = 6,
  parameter logic [PC_W-1:0]   TRAP_VECTOR = 'h180,
  parameter int unsigned       CNT_W       = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [PC_W-1:0]  pc,
  input  logic             ov_err,
  input  logic             adel_err,
  input  logic             ades_err,
  input  logic [N_IRQ-1:0] irq,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  output logic             redirect,
  output logic [PC_W-1:0]  trap_pc,
  output logic             trap_taken,
  output logic             is_syscall,
  output logic             is_break,
  output logic [5:0]       trap_type,
  output logic             in_handler
);

  state_t          r_state, w_state_nxt;
  logic            r_ie;
  logic [5:0]      r_im;
  logic [4:0]      r_exc;
  logic [PC_W-1:0] r_epc;
  logic            r_redirect;
  logic [PC_W-1:0] r_trap_pc;
  logic            r_trap_taken;
  logic            r_is_sys;
  logic            r_is_bp;
  logic [5:0]      r_trap_type;

  logic            w_exl;
  logic [5:0]      w_irq_pend;
  logic            w_trap;
  logic            w_eret;
  logic            w_is_sys;
  logic            w_is_bp;
  logic [4:0]      w_code;
  logic            w_cp0_wr;
  logic [31:0]     w_cnt_rd;

  assign w_exl      = (r_state == S_HANDLER);
  assign w_irq_pend = 6'(irq);
  // A trap or ERET in the same cycle takes precedence over MTC0.
  assign w_cp0_wr   = cp0_we & ~w_trap & ~w_eret;

  trap_decode u_decode (
    .i_squash      (r_redirect),
    .i_instr_valid (instr_valid),
    .i_instr       (instr),
    .i_ov_err      (ov_err),
    .i_adel_err    (adel_err),
    .i_ades_err    (ades_err),
    .i_irq_pend    (w_irq_pend),
    .i_im          (r_im),
    .i_ie          (r_ie),
    .i_exl         (w_exl),
    .o_trap        (w_trap),
    .o_eret        (w_eret),
    .o_is_sys      (w_is_sys),
    .o_is_bp       (w_is_bp),
    .o_code        (w_code)
  );

  // FSM state register; the state doubles as Status.EXL.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_NORMAL;
    else     r_state <= w_state_nxt;
  end

  // Next state: trap enters handler, ERET leaves, MTC0 Status may set EXL.
  always_comb begin
    w_state_nxt = r_state;
    if (w_trap)
      w_state_nxt = S_HANDLER;
    else if (w_eret)
      w_state_nxt = S_NORMAL;
    else if (w_cp0_wr && cp0_addr == CP0_STATUS)
      w_state_nxt = cp0_wdata[ST_EXL] ? S_HANDLER : S_NORMAL;
  end

  // CP0 registers and the registered one-cycle redirect/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie         <= 1'b0;
      r_im         <= '0;
      r_exc        <= '0;
      r_epc        <= '0;
      r_redirect   <= 1'b0;
      r_trap_pc    <= '0;
      r_trap_taken <= 1'b0;
      r_is_sys     <= 1'b0;
      r_is_bp      <= 1'b0;
      r_trap_type  <= '0;
    end else begin
      r_redirect   <= 1'b0;
      r_trap_pc    <= '0;
      r_trap_taken <= 1'b0;
      r_is_sys     <= 1'b0;
      r_is_bp      <= 1'b0;
      if (w_trap) begin
        r_redirect   <= 1'b1;
        r_trap_pc    <= TRAP_VECTOR;
        r_trap_taken <= 1'b1;
        r_is_sys     <= w_is_sys;
        r_is_bp      <= w_is_bp;
        r_trap_type  <= {1'b0, w_code};
        r_exc        <= w_code;
        if (!w_exl) r_epc <= pc;
      end else if (w_eret) begin
        r_redirect <= 1'b1;
        r_trap_pc  <= r_epc;
      end else if (w_cp0_wr) begin
        case (cp0_addr)
          CP0_STATUS: begin
            r_ie <= cp0_wdata[ST_IE];
            r_im <= cp0_wdata[ST_IM_HI:ST_IM_LO];
          end
          CP0_EPC: r_epc <= cp0_wdata[PC_W-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef TRAP_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of trap_taken pulses; MTC0 to its address clears it.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_cp0_wr && cp0_addr == CP0_TCNT)
      r_cnt <= '0;
    else if (r_trap_taken && r_cnt != '1)
      r_cnt <= r_cnt + 1'b1;
  end
  assign w_cnt_rd = 32'(r_cnt);
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
  assign w_cnt_rd     = '0;
`endif

  // MFC0 read mux.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_STATUS: cp0_rdata = {16'b0, r_im, 8'b0, w_exl, r_ie};
      CP0_CAUSE:  cp0_rdata = {16'b0, w_irq_pend, 3'b0, r_exc, 2'b0};
      CP0_EPC:    cp0_rdata = 32'(r_epc);
      CP0_TCNT:   cp0_rdata = w_cnt_rd;
      default:    cp0_rdata = '0;
    endcase
  end

  assign redirect   = r_redirect;
  assign trap_pc    = r_trap_pc;
  assign trap_taken = r_trap_taken;
  assign is_syscall = r_is_sys;
  assign is_break   = r_is_bp;
  assign trap_type  = r_trap_type;
  assign in_handler = w_exl;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a stimulus process drives one cycle at a
// time and pushes the reference model's expected outputs; a monitor pops and
// compares after every rising edge.
module tb_trap_ctrl;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned N_IRQ = 6;
  localparam logic [31:0] VEC   = 32'h0000_0180;
  localparam logic [31:0] ERET  = 32'h4200_0018;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        ov_err = 1'b0, adel_err = 1'b0, ades_err = 1'b0;
  logic [5:0]  irq = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] cp0_wdata = '0;
  logic [31:0] cp0_rdata;
  logic        redirect, trap_taken, is_syscall, is_break, in_handler;
  logic [31:0] trap_pc;
  logic [5:0]  trap_type;

  always #5 clk = ~clk;

  trap_ctrl #(.PC_W(PC_W), .N_IRQ(N_IRQ), .TRAP_VECTOR(VEC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .ov_err(ov_err), .adel_err(adel_err), .ades_err(ades_err), .irq(irq),
    .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .redirect(redirect), .trap_pc(trap_pc),
    .trap_taken(trap_taken), .is_syscall(is_syscall), .is_break(is_break),
    .trap_type(trap_type), .in_handler(in_handler)
  );

  typedef struct {
    logic        redirect;
    logic [31:0] tpc;
    logic        taken;
    logic        sys;
    logic        bp;
    logic [5:0]  ttype;
    logic        inh;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Architectural reference state.
  bit          m_exl, m_ie, m_redir, m_taken;
  bit [5:0]    m_im;
  bit [4:0]    m_code;
  bit [31:0]   m_epc;
  bit [5:0]    m_ttype;
  int unsigned m_cnt;

  int sup_ops[$] = '{'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B,
                     'h0C, 'h0D, 'h0E, 'h0F, 'h10, 'h20, 'h23, 'h24, 'h25,
                     'h28, 'h29, 'h2B};

  function automatic bit supported(input bit [5:0] op);
    foreach (sup_ops[i]) if (sup_ops[i] == int'(op)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the reference model's view of the next cycle.
  task automatic step(input bit r, input bit v, input bit [31:0] ins, input bit [31:0] p,
                      input bit ov, input bit adel, input bit ades, input bit [5:0] ir,
                      input bit we, input bit [4:0] addr, input bit [31:0] wd);
    exp_t     e;
    bit       sq, live, is_sys, is_bp, ri, eret_h, clr, new_taken, new_redir;
    bit       cond [7];
    int       codes [7] = '{0, 4, 10, 8, 9, 12, 5};
    int       sel;
    bit [31:0] tpc;
    @(negedge clk);
    rst = r; instr_valid = v; instr = ins; pc = p; ov_err = ov; adel_err = adel;
    ades_err = ades; irq = ir; cp0_we = we; cp0_addr = addr; cp0_wdata = wd;
    new_taken = 0; new_redir = 0; tpc = 0; clr = 0;
    e.sys = 0; e.bp = 0;
    if (r) begin
      m_exl = 0; m_ie = 0; m_im = 0; m_code = 0; m_epc = 0; m_ttype = 0; m_cnt = 0;
    end else begin
      sq     = m_redir;
      live   = v && !sq;
      is_sys = live && ins[31:26] == 0 && ins[5:0] == 12;
      is_bp  = live && ins[31:26] == 0 && ins[5:0] == 13;
      ri     = live && (!supported(ins[31:26]) || (ins == ERET && !m_exl));
      eret_h = live && ins == ERET && m_exl;
      cond   = '{!sq && m_ie && !m_exl && ((ir & m_im) != 0), live && adel, ri,
                 is_sys, is_bp, live && ov, live && ades};
      sel = -1;
      for (int i = 0; i < 7; i++) if (cond[i] && sel < 0) sel = i;
      if (sel >= 0) begin
        new_taken = 1; new_redir = 1; tpc = VEC;
        e.sys = (codes[sel] == 8); e.bp = (codes[sel] == 9);
        m_code = 5'(codes[sel]); m_ttype = 6'(codes[sel]);
        if (!m_exl) m_epc = p;
        m_exl = 1;
      end else if (eret_h) begin
        new_redir = 1; tpc = m_epc; m_exl = 0;
      end else if (we) begin
        if (addr == 12) begin m_ie = wd[0]; m_exl = wd[1]; m_im = wd[15:10]; end
        if (addr == 14) m_epc = wd;
        if (addr == 22) clr = 1;
      end
      if (clr) m_cnt = 0;
      else if (m_taken && m_cnt < 32'hFFFF) m_cnt++;
    end
    m_taken = new_taken; m_redir = new_redir;
    e.redirect = new_redir; e.tpc = tpc; e.taken = new_taken;
    e.ttype = m_ttype; e.inh = m_exl;
    case (addr)
      12: e.rdata = {16'b0, m_im, 8'b0, m_exl, m_ie};
      13: e.rdata = {16'b0, ir, 3'b0, m_code, 2'b0};
      14: e.rdata = m_epc;
`ifdef TRAP_CNT_EN
      22: e.rdata = m_cnt;
`endif
      default: e.rdata = 0;
    endcase
    q.push_back(e);
  endtask

  task automatic run(input bit [31:0] ins, input bit [31:0] p, input bit [4:0] addr);
    step(0, 1, ins, p, 0, 0, 0, 0, 0, addr, 0);
  endtask

  task automatic idle(input bit [4:0] addr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, addr, 0);
  endtask

  // Monitor: compare every registered output one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("redirect",   32'(redirect),   32'(e.redirect));
        chk("trap_pc",    trap_pc,         e.tpc);
        chk("trap_taken", 32'(trap_taken), 32'(e.taken));
        chk("is_syscall", 32'(is_syscall), 32'(e.sys));
        chk("is_break",   32'(is_break),   32'(e.bp));
        chk("trap_type",  32'(trap_type),  32'(e.ttype));
        chk("in_handler", 32'(in_handler), 32'(e.inh));
        chk("cp0_rdata",  cp0_rdata,       e.rdata);
      end
    end
  end

  function automatic bit [31:0] rand_instr();
    bit [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: return {6'd0, w[25:6], 6'd12};
      1: return {6'd0, w[25:6], 6'd13};
      2: return ERET;
      3: return 32'h0253_4820;
      4: return w;
      5: return {6'h23, w[25:0]};
      default: return {6'd0, w[25:0]};
    endcase
  endfunction

  initial begin
    bit [4:0] addrs [5] = '{12, 13, 14, 22, 3};
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 14, 0);
    // SYSCALL, then ERET back to EPC
    run(32'h0000_000C, 32'h0040_0010, 14);
    idle(14);
    idle(12);
    run(ERET, 32'h180, 13);
    idle(12);
    // BREAK with code field, then ERET
    run(32'h0004_8D0D, 32'h0040_0020, 13);
    idle(14);
    run(ERET, 32'h184, 12);
    idle(12);
    // SYSCALL with overflow: Sys wins; plain ADD: no trap
    step(0, 1, 32'h0000_000C, 32'h0040_0030, 1, 0, 0, 0, 0, 13, 0);
    idle(13);
    run(ERET, 32'h188, 12);
    idle(12);
    run(32'h0253_4820, 32'h0040_0040, 13);
    idle(13);
    // Interrupt enabled via MTC0 Status
    step(0, 0, 0, 0, 0, 0, 0, 6'b000001, 1, 12, 32'h0000_0401);
    step(0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 13, 0);
    idle(13);
    run(ERET, 32'h18C, 12);
    idle(12);
    // Same with EXL set: no interrupt
    step(0, 0, 0, 0, 0, 0, 0, 6'b000001, 1, 12, 32'h0000_0403);
    step(0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 13, 0);
    step(0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 12, 0);
    step(0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 12, 32'h0000_0000);
    idle(12);
    // Nested SYSCALL keeps the first EPC
    run(32'h0000_000C, 32'h0040_0100, 14);
    idle(14);
    run(32'h0000_000C, 32'h0000_0190, 14);
    idle(14);
    // ERET followed by a SYSCALL in the redirect (squash) cycle
    run(ERET, 32'h194, 12);
    run(32'h0000_000C, 32'h0040_0104, 12);
    idle(13);
    // ERET in NORMAL is RI
    run(ERET, 32'h0040_0200, 13);
    idle(13);
    run(ERET, 32'h180, 12);
    idle(12);
    // Reset while in the handler
    run(32'h0000_000C, 32'h0040_0300, 14);
    idle(12);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    idle(14);
    idle(13);
    // Three traps for the counter, then reset clears it
    for (int k = 0; k < 3; k++) begin
      run(32'h0000_000C, 32'h0040_0400 + 32'(k * 4), 22);
      idle(22);
      run(ERET, 32'h180, 22);
      idle(22);
    end
    idle(22);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 22, 0);
    idle(22);
    // Randomised traffic
    for (int n = 0; n < 700; n++) begin
      bit        rr, vv, ov, ae, se, we;
      bit [5:0]  ir;
      bit [31:0] wd;
      rr = ($urandom_range(0, 199) == 0);
      vv = ($urandom_range(0, 3) != 0);
      ov = ($urandom_range(0, 7) == 0);
      ae = ($urandom_range(0, 11) == 0);
      se = ($urandom_range(0, 9) == 0);
      ir = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      we = ($urandom_range(0, 5) == 0);
      wd = $urandom;
      if ($urandom_range(0, 1) == 0) wd[1] = 1'b0;
      step(rr, vv, rand_instr(), $urandom & 32'hFFFF_FFFC, ov, ae, se, ir, we,
           addrs[$urandom_range(0, 4)], wd);
    end
    idle(12);
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential successor to the combinational SYSCALL/BREAK decoder: a CP0-lite trap controller.
- Detects SYSCALL, BREAK, reserved opcode, overflow, address errors, masked external interrupts and ERET on the committing instruction. It prioritises them and latches EPC/Cause/Status.
- Issues a registered one-cycle redirect and flush to the PC unit. Sits beside the commit stage of the MIPS core.

Parameters:
- PC_W, 32, width of pc/EPC/redirect target.
- N_IRQ, 6, number of level-sensitive interrupt lines; maximum 6.
- TRAP_VECTOR, 32'h0000_0180, handler entry address.
- CNT_W, 16, width of the trap counter (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  instruction commits this cycle.
- instr  in  32  committing instruction word.
- pc  in  PC_W  pc of committing instruction.
- ov_err  in  1  arithmetic overflow on this instruction.
- adel_err  in  1  load/fetch address error.
- ades_err  in  1  store address error.
- irq  in  N_IRQ  external interrupt lines, level.
- cp0_we  in  1  MTC0 write strobe.
- cp0_addr  in  5  CP0 register select.
- cp0_wdata  in  32  MTC0 data.
- cp0_rdata  out  32  MFC0 data, combinational from cp0_addr.
- redirect  out  1  flush pipeline and load trap_pc; one-cycle pulse.
- trap_pc  out  PC_W  redirect target.
- trap_taken  out  1  pulse, exception/interrupt entered.
- is_syscall  out  1  pulse aligned with trap_taken.
- is_break  out  1  pulse aligned with trap_taken.
- trap_type  out  6  ExcCode of last trap, held.
- in_handler  out  1  Status.EXL.

Behaviour:
- Reset: all outputs 0; Status=0, Cause=0, EPC=0; FSM to NORMAL; squash flag clear.
- Decode:
  - SYSCALL: opcode=0, funct=12; code field [25:6] ignored.
  - BREAK: opcode=0, funct=13; code field [25:6] ignored.
  - ERET: instr==32'h4200_0018.
  - RI: opcode not in the package's supported list.
- ExcCodes: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
- Priority, highest first: Int > AdEL > RI > Sys > Bp > Ov > AdES. Int condition is IE & ~EXL & |(irq & IM); all others require instr_valid.
- Latency: detection in cycle N; redirect, trap_taken, trap_pc, trap_type and pulses are registered and visible in N+1 for exactly one cycle (trap_type holds).
- Squash: in the cycle redirect=1, instr_valid is ignored (flushing); no detection.
- FSM NORMAL -> HANDLER on any trap:
  - EXL<=1; EPC<=pc; Cause.ExcCode<=code; trap_pc=TRAP_VECTOR.
  - Interrupt suppresses the committing instruction; EPC=pc.
- In HANDLER:
  - Interrupts masked.
  - A synchronous exception still traps to TRAP_VECTOR and updates ExcCode, but EPC is not overwritten (nested, MIPS rule).
- ERET in HANDLER: redirect to EPC; EXL<=0; -> NORMAL; no trap_taken.
- ERET in NORMAL: raises RI (code 10).
- CP0 map:
  - 12 Status: bit0 IE, bit1 EXL, [15:10] IM; others read 0.
  - 13 Cause: [6:2] ExcCode, [15:10] live irq pending; read-only.
  - 14 EPC: read/write.
  - Other addresses read 0; writes ignored.
- MTC0 in the same cycle as a trap: write dropped; trap wins.
- MTC0 Status with IE=1 while irq pending: interrupt can be taken no earlier than the next cycle.
- irq lines above N_IRQ read 0.

Optional Feature:
- TRAP_CNT_EN defined:
  - CNT_W-bit saturating counter of trap_taken pulses, readable at cp0_addr 22.
  - Cleared by reset or any MTC0 to 22.
  - Saturates at all-ones with no wrap.
- Without the macro: no counter logic; address 22 reads 0.

Decomposition:
- Package trap_pkg holds:
  - ExcCode localparams.
  - CP0 address constants 12/13/14/22.
  - Status bit indices.
  - Supported-opcode list.
  - FSM state encoding.
  - ERET encoding.
- One sub-module, trap_decode: combinational classification and priority selection. trap_ctrl keeps the FSM, registers and CP0 access.

Test Plan:
- instr=32'h0000_000C, pc=32'h0040_0010, valid -> next cycle trap_taken=1, is_syscall=1, trap_type=8, trap_pc=32'h180, EPC reads 32'h0040_0010, in_handler=1.
- BREAK then ERET in handler -> trap_type=9, redirect to EPC, in_handler=0, trap_taken=0 on the ERET cycle.
- Two traps in one instruction: ov_err=1 with SYSCALL encoding -> trap_type=8. ADD (32'h0253_4820) with no errors -> no trap, all pulses 0.
- Interrupt gating: Status=32'h0000_0401 via MTC0, irq=6'b000001 -> Int trap with code 0 next cycle. Same with EXL=1 -> no trap.
- Nested and squash:
  - Nested: SYSCALL in handler -> EPC unchanged, trap_pc=32'h180.
  - Squash: SYSCALL with instr_valid asserted in the redirect cycle -> ignored.
  - ERET in NORMAL -> trap_type=10.
- Reset mid-handler: rst=1 -> Status/Cause/EPC=0, redirect=0, NORMAL. With TRAP_CNT_EN: 3 traps -> cp0_addr 22 reads 3; after reset reads 0.
